// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: three debounced buttons drive an IDLE/RUN/STOP/OVF FSM
// that counts packed BCD hundredths (SS.cc) from a TICK_DIV-cycle prescaler.
//
// state | meaning
// IDLE  | cleared, digits 0000, waiting for start
// RUN   | prescaler counting, digits advance once per TICK_DIV cycles
// STOP  | paused, prescaler and digits frozen, start resumes
// OVF   | 99.99 reached and another tick arrived, only clear exits
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        btn_start_i,
  input  logic        btn_stop_i,
  input  logic        btn_clear_i,
  output logic [15:0] digits_o,
  output logic        running_o,
  output logic        overflow_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_OVF  = 2'd3;

  logic [2:0] btn_raw;
  logic [2:0] press;
  logic [1:0] vld_q;

  assign btn_raw = {btn_clear_i, btn_stop_i, btn_start_i};

  // vld_q[1] marks that the second synchronizer stage holds a real sample
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vld_q <= 2'b00;
    else          vld_q <= {vld_q[0], 1'b1};
  end

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic          s1_q, s2_q, deb_q, deb_d1_q, armed_q, press_q;
    logic [CW-1:0] cnt_q;

    // A button is armed only after it has been seen low, so one held through reset never fires
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        deb_q    <= 1'b0;
        deb_d1_q <= 1'b0;
        armed_q  <= 1'b0;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q <= btn_raw[b];
        s2_q <= s1_q;
        if (s2_q != deb_q) begin
          if (cnt_q == DEB_LAST) begin
            deb_q <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
        deb_d1_q <= deb_q;
        if (vld_q[1] && !s2_q) armed_q <= 1'b1;
        press_q <= armed_q & deb_q & ~deb_d1_q;
      end
    end

    assign press[b] = press_q;
  end

  logic          ev_start, ev_stop, ev_clear;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   digits_q, digits_d;
  logic          running_q, overflow_q;

  assign ev_start = press[0];
  assign ev_stop  = press[1];
  assign ev_clear = press[2];

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Only the highest-priority event (clear > stop > start) is acted on
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    case (state_q)
      S_IDLE: if (ev_start && !ev_stop && !ev_clear) state_d = S_RUN;
      S_RUN: begin
        if (ev_clear) begin
          state_d = S_IDLE;
        end else if (ev_stop) begin
          state_d = S_STOP;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (digits_q == 16'h9999) state_d = S_OVF;
          else                      digits_d = bcd_inc(digits_q);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (ev_clear)                 state_d = S_IDLE;
        else if (ev_start && !ev_stop) state_d = S_RUN;
      end
      S_OVF: if (ev_clear) state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      presc_d  = '0;
      digits_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      digits_q   <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      running_q  <= (state_d == S_RUN);
      overflow_q <= (state_d == S_OVF);
    end
  end

  assign digits_o   = digits_q;
  assign running_o  = running_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, giving clk cycles per hundredth-second increment (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536, giving the number of consecutive cycles a synchronized button level must differ before it is accepted (minimum 2).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 btn_start  input  1  raw asynchronous button, active-high.
REQ-007 btn_stop  input  1  raw asynchronous button, active-high.
REQ-008 btn_clear  input  1  raw asynchronous button, active-high.
REQ-009 digits  output  16  four packed BCD digits SS.cc: [3:0] hundredths, [7:4] tenths, [11:8] seconds units, [15:12] seconds tens; feeds the 7-segment display multiplexer.
REQ-010 running  output  1  high while in RUN.
REQ-011 overflow  output  1  high while in OVF.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a debouncer of DEBOUNCE_CYCLES, then a rising-edge detector producing a one-cycle press event.
REQ-013 Debouncer SHALL count cycles where the synced level differs from the debounced level, clear the count when they agree, and update the debounced level when the count reaches DEBOUNCE_CYCLES.
REQ-014 SHALL raise exactly one press event per accepted low-to-high transition; holding a button SHALL NOT repeat the event.
REQ-015 FSM states: IDLE, RUN, STOP, OVF.
REQ-016 IDLE: start -> RUN; stop ignored.
REQ-017 RUN: clear -> IDLE; stop -> STOP; increment while digits == 9999 -> OVF.
REQ-018 STOP: start -> RUN (resume, no clearing); clear -> IDLE.
REQ-019 OVF: clear -> IDLE; start and stop ignored.
REQ-020 Simultaneous events SHALL resolve with priority clear > stop > start.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold in STOP and OVF, and be zeroed when entering IDLE.
REQ-022 In RUN, when the prescaler equals TICK_DIV-1, it SHALL wrap to 0 and digits SHALL increment by one hundredth on the same edge.
REQ-023 Increment SHALL be BCD with ripple carry. Each digit wraps 9 -> 0 and carries into the next. 0099 -> 0100. 0999 -> 1000.
REQ-024 An increment at 9999 SHALL leave digits at 9999 and enter OVF. Digits SHALL never wrap to 0000.
REQ-025 A stop event coinciding with a prescaler wrap SHALL suppress that increment. The prescaler and digits SHALL hold, so the increment occurs on the first RUN cycle after resume.
REQ-026 Entering IDLE SHALL set digits to 0000 on the same edge.
REQ-027 digits, running and overflow SHALL be registered outputs. No BCD digit SHALL ever exceed 9.
REQ-028 From the first edge sampling a raw button high and held, the FSM state SHALL change exactly DEBOUNCE_CYCLES+3 edges later.

Reset
REQ-029 rst_n low SHALL immediately set: state IDLE, digits 0000, running 0, overflow 0, prescaler 0, synchronizers/debounced levels/debounce counters 0.
REQ-030 Reset asserted mid-RUN or in OVF SHALL discard all count, and no press event SHALL be generated on release of reset.
REQ-031 Release of rst_n is synchronized by the system; the block SHALL be operational on the first edge after deassertion.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-032 Press start, 3+3 edges -> running=1; after 40 further cycles digits=0x0010; press stop -> running=0, digits frozen.
REQ-033 Glitch btn_start high for 2 cycles -> no state change, digits stay 0x0000.
REQ-034 Preload via run to 0x0099, next tick -> 0x0100; from 0x9999, tick -> digits stay 0x9999, overflow=1; start/stop ignored; clear -> 0x0000, overflow=0.
REQ-035 Assert stop and clear events on the same cycle in RUN -> IDLE, digits=0x0000; stop coincident with wrap -> no increment until resume.
REQ-036 Pulse rst_n low mid-RUN with btn_start held high -> outputs zero asynchronously; after release, no restart until btn_start is released and pressed again.
